// File: rtl/pwm_slew_sched.sv
// Purpose : round-robin slew scheduler for the three PWM duty inputs; services one channel per tick,
//           halves a channel on current-limit and holds it off from rising, zeroes all when motor is off.
// Latency : a serviced channel's duty changes the clk after the tick; no backpressure (tick is a strobe).
// Ports   : clk, reset (async, active-high), tick, motorena, target0..2, currentlimit0..2 in;
//           duty0..2, slot (next channel to service), settled[2:0], limiting[2:0] out.
// Option  : define CURRENTLIMIT_SYNC_EN to pass each currentlimitk through a 2-flop synchronizer
//           (adds 2 clk of sampling latency); undefined means the limits are already synchronous.
module pwm_slew_sched #(
  parameter int unsigned STEP    = 1,
  parameter int unsigned HOLDOFF = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       motorena,
  input  logic [7:0] target0,
  input  logic [7:0] target1,
  input  logic [7:0] target2,
  input  logic       currentlimit0,
  input  logic       currentlimit1,
  input  logic       currentlimit2,
  output logic [7:0] duty0,
  output logic [7:0] duty1,
  output logic [7:0] duty2,
  output logic [1:0] slot,
  output logic [2:0] settled,
  output logic [2:0] limiting
);

  typedef enum logic [1:0] {
    S0 = 2'd0,
    S1 = 2'd1,
    S2 = 2'd2
  } slot_e;

  localparam logic [8:0] STEP9 = 9'(STEP);
  localparam logic [7:0] HOLD8 = 8'(HOLDOFF);

  slot_e           slot_q, slot_d;
  logic [2:0][7:0] duty_q, duty_d;
  logic [2:0][7:0] holdoff_q, holdoff_d;
  logic [2:0][7:0] tgt;
  logic [2:0]      cl;
  logic [1:0]      slot_sel;

  assign tgt      = {target2, target1, target0};
  assign slot_sel = slot_q;

`ifdef CURRENTLIMIT_SYNC_EN
  logic [2:0] cl_meta_q, cl_sync_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cl_meta_q <= '0;
      cl_sync_q <= '0;
    end else begin
      cl_meta_q <= {currentlimit2, currentlimit1, currentlimit0};
      cl_sync_q <= cl_meta_q;
    end
  end

  assign cl = cl_sync_q;
`else
  assign cl = {currentlimit2, currentlimit1, currentlimit0};
`endif

  // Move cur toward tg by at most STEP, landing exactly on tg when within STEP.
  // The 9-bit compare keeps the move from wrapping: an overshoot is always caught
  // by the "within STEP" branch, so cur+STEP / cur-STEP only occur strictly inside 0..255.
  // allow_up=0 freezes upward moves while a channel is in holdoff.
  function automatic logic [7:0] slew_to(input logic [7:0] cur, input logic [7:0] tg,
                                         input logic allow_up);
    logic [8:0] c9, t9;
    logic [7:0] r;
    c9 = {1'b0, cur};
    t9 = {1'b0, tg};
    r  = cur;
    if (t9 > c9) begin
      if (allow_up) r = ((t9 - c9) <= STEP9) ? tg : 8'(c9 + STEP9);
    end else begin
      r = ((c9 - t9) <= STEP9) ? tg : 8'(c9 - STEP9);
    end
    return r;
  endfunction

  always_comb begin
    duty_d    = duty_q;
    holdoff_d = holdoff_q;
    slot_d    = slot_q;
    if (!motorena) begin
      // Motor off wins over tick; holdoff counters keep their value so a
      // channel that just tripped does not come back at full rate.
      duty_d = '0;
      slot_d = S0;
    end else if (tick) begin
      for (int k = 0; k < 3; k++) begin
        if (slot_sel == 2'(k)) begin
          if (cl[k]) begin
            duty_d[k]    = {1'b0, duty_q[k][7:1]};
            holdoff_d[k] = HOLD8;
          end else if (holdoff_q[k] != 8'd0) begin
            holdoff_d[k] = holdoff_q[k] - 8'd1;
            duty_d[k]    = slew_to(duty_q[k], tgt[k], 1'b0);
          end else begin
            duty_d[k]    = slew_to(duty_q[k], tgt[k], 1'b1);
          end
        end
      end
      case (slot_q)
        S0:      slot_d = S1;
        S1:      slot_d = S2;
        default: slot_d = S0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      slot_q    <= S0;
      duty_q    <= '0;
      holdoff_q <= '0;
    end else begin
      slot_q    <= slot_d;
      duty_q    <= duty_d;
      holdoff_q <= holdoff_d;
    end
  end

  assign duty0 = duty_q[0];
  assign duty1 = duty_q[1];
  assign duty2 = duty_q[2];
  assign slot  = slot_q;

  always_comb begin
    settled  = '0;
    limiting = '0;
    for (int k = 0; k < 3; k++) begin
      limiting[k] = (holdoff_q[k] != 8'd0);
      settled[k]  = (duty_q[k] == tgt[k]) && (holdoff_q[k] == 8'd0);
    end
  end

endmodule

// File: tb/tb_pwm_slew_sched.sv
// Bench for pwm_slew_sched: three instances (STEP 1/16/200) share all inputs and are
// compared every cycle against an arithmetic model of the slew/holdoff/motor rules,
// plus fixed-value checks of the ramp, step-down, current-limit, reset and no-wrap cases.
module tb_pwm_slew_sched;

  logic       clk = 1'b0;
  logic       reset;
  logic       tick;
  logic       motorena;
  logic [7:0] target0, target1, target2;
  logic       currentlimit0, currentlimit1, currentlimit2;

  logic [7:0] o_d0[3];
  logic [7:0] o_d1[3];
  logic [7:0] o_d2[3];
  logic [1:0] o_slot[3];
  logic [2:0] o_set[3];
  logic [2:0] o_lim[3];

  int n_chk  = 0;
  int n_pass = 0;

  int stp[3] = '{1, 16, 200};
  int hld[3] = '{16, 16, 4};

  // Reference model state.
  int md[3][3];
  int mh[3][3];
  int mslot;
  bit clh1[3];
  bit clh2[3];

  always #5 clk = ~clk;

  pwm_slew_sched #(.STEP(1), .HOLDOFF(16)) u_a (
    .clk(clk), .reset(reset), .tick(tick), .motorena(motorena),
    .target0(target0), .target1(target1), .target2(target2),
    .currentlimit0(currentlimit0), .currentlimit1(currentlimit1), .currentlimit2(currentlimit2),
    .duty0(o_d0[0]), .duty1(o_d1[0]), .duty2(o_d2[0]),
    .slot(o_slot[0]), .settled(o_set[0]), .limiting(o_lim[0])
  );

  pwm_slew_sched #(.STEP(16), .HOLDOFF(16)) u_b (
    .clk(clk), .reset(reset), .tick(tick), .motorena(motorena),
    .target0(target0), .target1(target1), .target2(target2),
    .currentlimit0(currentlimit0), .currentlimit1(currentlimit1), .currentlimit2(currentlimit2),
    .duty0(o_d0[1]), .duty1(o_d1[1]), .duty2(o_d2[1]),
    .slot(o_slot[1]), .settled(o_set[1]), .limiting(o_lim[1])
  );

  pwm_slew_sched #(.STEP(200), .HOLDOFF(4)) u_c (
    .clk(clk), .reset(reset), .tick(tick), .motorena(motorena),
    .target0(target0), .target1(target1), .target2(target2),
    .currentlimit0(currentlimit0), .currentlimit1(currentlimit1), .currentlimit2(currentlimit2),
    .duty0(o_d0[2]), .duty1(o_d1[2]), .duty2(o_d2[2]),
    .slot(o_slot[2]), .settled(o_set[2]), .limiting(o_lim[2])
  );

  function automatic int tgt_of(int k);
    return (k == 0) ? int'(target0) : (k == 1) ? int'(target1) : int'(target2);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++)
      for (int k = 0; k < 3; k++) begin
        md[i][k] = 0;
        mh[i][k] = 0;
      end
    mslot = 0;
    for (int k = 0; k < 3; k++) begin
      clh1[k] = 1'b0;
      clh2[k] = 1'b0;
    end
  endtask

  // One clock edge of the specified behaviour, from the inputs held across it.
  task automatic model_edge();
    bit cl_in[3];
    bit cl[3];
    int k, t, d;
    cl_in[0] = currentlimit0;
    cl_in[1] = currentlimit1;
    cl_in[2] = currentlimit2;
    if (reset) begin
      model_reset();
      return;
    end
    for (int c = 0; c < 3; c++) begin
`ifdef CURRENTLIMIT_SYNC_EN
      cl[c] = clh2[c];
`else
      cl[c] = cl_in[c];
`endif
    end
    if (!motorena) begin
      for (int i = 0; i < 3; i++)
        for (int c = 0; c < 3; c++) md[i][c] = 0;
      mslot = 0;
    end else if (tick) begin
      k = mslot;
      t = tgt_of(k);
      for (int i = 0; i < 3; i++) begin
        d = md[i][k];
        if (cl[k]) begin
          md[i][k] = d / 2;
          mh[i][k] = hld[i];
        end else if (mh[i][k] > 0) begin
          mh[i][k] = mh[i][k] - 1;
          if (t < d) md[i][k] = (d - t <= stp[i]) ? t : d - stp[i];
        end else begin
          if (((t > d) ? t - d : d - t) <= stp[i]) md[i][k] = t;
          else if (t > d) md[i][k] = d + stp[i];
          else md[i][k] = d - stp[i];
        end
      end
      mslot = (mslot + 1) % 3;
    end
    for (int c = 0; c < 3; c++) begin
      clh2[c] = clh1[c];
      clh1[c] = cl_in[c];
    end
  endtask

  function automatic logic [31:0] expv(int i);
    logic [2:0] s, l;
    for (int k = 0; k < 3; k++) begin
      s[k] = (md[i][k] == tgt_of(k)) && (mh[i][k] == 0);
      l[k] = (mh[i][k] != 0);
    end
    return {8'(md[i][0]), 8'(md[i][1]), 8'(md[i][2]), 2'(mslot), s, l};
  endfunction

  function automatic logic [31:0] obs(int i);
    return {o_d0[i], o_d1[i], o_d2[i], o_slot[i], o_set[i], o_lim[i]};
  endfunction

  // Advance one clock: model follows the edge, return at the falling edge for sampling/driving.
  task automatic cyc();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1; tick = 1'b0; motorena = 1'b0;
    target0 = 8'h40; target1 = 8'h00; target2 = 8'h00;
    currentlimit0 = 1'b0; currentlimit1 = 1'b0; currentlimit2 = 1'b0;
    model_reset();
    cyc();
    cyc();
    for (int i = 0; i < 3; i++) begin
      n_chk++;
      if (obs(i) !== {8'h00, 8'h00, 8'h00, 2'd0, 3'b110, 3'b000})
        $display("FAIL reset_state inst%0d got %h want %h", i, obs(i),
                 {8'h00, 8'h00, 8'h00, 2'd0, 3'b110, 3'b000});
      else n_pass++;
    end
    reset = 1'b0;
  endtask

  task automatic test_ramp();
    logic [1:0] want_slot;
    motorena = 1'b1; tick = 1'b1;
    for (int c = 0; c < 192; c++) begin
      cyc();
      for (int i = 0; i < 3; i++) begin
        n_chk++;
        if (obs(i) !== expv(i))
          $display("FAIL ramp inst%0d cyc%0d got %h want %h", i, c, obs(i), expv(i));
        else n_pass++;
      end
      want_slot = 2'((c + 1) % 3);
      n_chk++;
      if (o_slot[0] !== want_slot)
        $display("FAIL ramp_slot cyc%0d got %0d want %0d", c, o_slot[0], want_slot);
      else n_pass++;
    end
    n_chk++;
    if ({o_d0[0], o_d1[0], o_d2[0], o_set[0][0]} !== {8'h40, 8'h00, 8'h00, 1'b1})
      $display("FAIL ramp_end got d0=%h d1=%h d2=%h set0=%b want 40 00 00 1",
               o_d0[0], o_d1[0], o_d2[0], o_set[0][0]);
    else n_pass++;
  endtask

  task automatic test_currentlimit();
    int guard;
    target0 = 8'h80;
    for (int c = 0; c < 200; c++) begin
      cyc();
      for (int i = 0; i < 3; i++) begin
        n_chk++;
        if (obs(i) !== expv(i))
          $display("FAIL cl_rise inst%0d got %h want %h", i, obs(i), expv(i));
        else n_pass++;
      end
    end
    guard = 0;
    while (mslot != 0 && guard < 3) begin
      cyc();
      guard++;
    end
    currentlimit0 = 1'b1;
    cyc();
    currentlimit0 = 1'b0;
`ifndef CURRENTLIMIT_SYNC_EN
    n_chk++;
    if ({o_d0[0], o_lim[0][0]} !== {8'h40, 1'b1})
      $display("FAIL cl_halve got d0=%h lim0=%b want 40 1", o_d0[0], o_lim[0][0]);
    else n_pass++;
`endif
    for (int c = 0; c < 260; c++) begin
      cyc();
      for (int i = 0; i < 3; i++) begin
        n_chk++;
        if (obs(i) !== expv(i))
          $display("FAIL cl_hold inst%0d cyc%0d got %h want %h", i, c, obs(i), expv(i));
        else n_pass++;
      end
    end
    n_chk++;
    if ({o_d0[0], o_lim[0][0]} !== {8'h80, 1'b0})
      $display("FAIL cl_recover got d0=%h lim0=%b want 80 0", o_d0[0], o_lim[0][0]);
    else n_pass++;
  endtask

  task automatic test_step_down();
    logic [7:0] seq[5];
    int n;
    bit svc;
    seq = '{8'hB0, 8'hA0, 8'h90, 8'h80, 8'h80};
    target1 = 8'hC0;
    for (int c = 0; c < 600; c++) begin
      cyc();
      for (int i = 0; i < 3; i++) begin
        n_chk++;
        if (obs(i) !== expv(i))
          $display("FAIL step_rise inst%0d got %h want %h", i, obs(i), expv(i));
        else n_pass++;
      end
    end
    target1 = 8'h80;
    n = 0;
    for (int c = 0; c < 15 && n < 5; c++) begin
      svc = (mslot == 1);
      cyc();
      if (svc) begin
        n_chk++;
        if (o_d1[1] !== seq[n])
          $display("FAIL step_down svc%0d got %h want %h", n, o_d1[1], seq[n]);
        else n_pass++;
        n++;
      end
    end
  endtask

  task automatic test_motor_off();
    target0 = 8'hFF; target1 = 8'h10; target2 = 8'h70;
    for (int c = 0; c < 20; c++) cyc();
    motorena = 1'b0;
    cyc();
    for (int i = 0; i < 3; i++) begin
      n_chk++;
      if ({o_d0[i], o_d1[i], o_d2[i], o_slot[i]} !== 26'd0)
        $display("FAIL motor_off inst%0d got %h want 0", i, {o_d0[i], o_d1[i], o_d2[i], o_slot[i]});
      else n_pass++;
    end
    motorena = 1'b1;
    for (int c = 0; c < 12; c++) begin
      cyc();
      for (int i = 0; i < 3; i++) begin
        n_chk++;
        if (obs(i) !== expv(i))
          $display("FAIL motor_resume inst%0d got %h want %h", i, obs(i), expv(i));
        else n_pass++;
      end
    end
  endtask

  task automatic test_async_reset();
    for (int c = 0; c < 10; c++) cyc();
    @(posedge clk);
    model_edge();
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    for (int i = 0; i < 3; i++) begin
      n_chk++;
      if ({o_d0[i], o_d1[i], o_d2[i], o_slot[i], o_lim[i]} !== 31'd0)
        $display("FAIL async_reset inst%0d got %h want 0", i,
                 {o_d0[i], o_d1[i], o_d2[i], o_slot[i], o_lim[i]});
      else n_pass++;
    end
    #1;
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_no_wrap();
    logic [7:0] seq[3];
    int n;
    bit svc;
    seq = '{8'hFF, 8'h37, 8'h00};
    target0 = 8'h00; target1 = 8'h00; target2 = 8'hF0;
    for (int c = 0; c < 9; c++) cyc();
    n_chk++;
    if (o_d2[2] !== 8'hF0) $display("FAIL wrap_pre got %h want f0", o_d2[2]);
    else n_pass++;
    n = 0;
    target2 = 8'hFF;
    for (int c = 0; c < 12 && n < 3; c++) begin
      svc = (mslot == 2);
      cyc();
      for (int i = 0; i < 3; i++) begin
        n_chk++;
        if (obs(i) !== expv(i))
          $display("FAIL wrap inst%0d got %h want %h", i, obs(i), expv(i));
        else n_pass++;
      end
      if (svc) begin
        n_chk++;
        if (o_d2[2] !== seq[n]) $display("FAIL wrap_seq svc%0d got %h want %h", n, o_d2[2], seq[n]);
        else n_pass++;
        n++;
        target2 = 8'h00;
      end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 1500; c++) begin
      tick          = ($urandom_range(0, 3) != 0);
      motorena      = ($urandom_range(0, 49) != 0);
      currentlimit0 = ($urandom_range(0, 19) == 0);
      currentlimit1 = ($urandom_range(0, 19) == 0);
      currentlimit2 = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 29) == 0) target0 = 8'($urandom);
      if ($urandom_range(0, 29) == 0) target1 = 8'($urandom);
      if ($urandom_range(0, 29) == 0) target2 = 8'($urandom);
      cyc();
      for (int i = 0; i < 3; i++) begin
        n_chk++;
        if (obs(i) !== expv(i))
          $display("FAIL random inst%0d cyc%0d got %h want %h", i, c, obs(i), expv(i));
        else n_pass++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_ramp();
    test_currentlimit();
    test_step_down();
    test_motor_off();
    test_async_reset();
    test_no_wrap();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/pwm_slew_sched.md
Name: pwm_slew_sched

Overview:
Round-robin scheduler that owns the duty-cycle inputs of the three PWM channels. It slews each channel's applied duty toward its SPI-written target, one channel per scheduler tick. It backs a channel off when its current-limit input asserts, and forces all duties to zero when the motor is disabled. It sits between the SPI register file (targets, motorena) and the three PWM generators.

Parameters:
STEP, 1, duty change per service of a channel (1..255)
HOLDOFF, 16, services a channel is blocked from increasing after a current-limit event (1..255)

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
tick  input  1  one-clk scheduler strobe from prescaler
motorena  input  1  motor enable (watchdog-qualified)
target0  input  8  channel 0 target duty from register file
target1  input  8  channel 1 target duty
target2  input  8  channel 2 target duty
currentlimit0  input  1  channel 0 over-current, active-high
currentlimit1  input  1  channel 1 over-current
currentlimit2  input  1  channel 2 over-current
duty0  output  8  applied duty to PWM channel 0
duty1  output  8  applied duty to PWM channel 1
duty2  output  8  applied duty to PWM channel 2
slot  output  2  channel to be serviced on next tick (0,1,2)
settled  output  3  bit k = (dutyk == targetk) and holdoff_k == 0
limiting  output  3  bit k = holdoff_k != 0

Behaviour:
- Reset (async): duty0..2=0, slot=0, holdoff counters=0, limiting=0; settled is combinational from these.
- Slot FSM states S0,S1,S2. On clk edge with tick=1 and motorena=1: service channel slot, then slot advances S0->S1->S2->S0. tick=0: no state change.
- Service of channel k (registered; dutyk visible the cycle after the tick):
  - cl_k=1: dutyk <= dutyk>>1; holdoff_k <= HOLDOFF.
  - else if holdoff_k!=0: holdoff_k decrements by 1. If targetk<dutyk, step down as below; otherwise dutyk holds.
  - else slew: if |targetk-dutyk| <= STEP, dutyk <= targetk; else dutyk moves toward targetk by STEP.
  - Arithmetic uses 9-bit intermediates; dutyk never wraps past 0x00 or 0xFF.
- motorena=0: on the next edge, all duties=0, slot=0, and holdoff counters hold their values. This happens regardless of tick, and motorena=0 takes priority over tick.
- Channels not in the current slot are untouched. Current-limit assertion on an unserviced channel is acted on only when that channel's slot arrives. cl_k is level-sampled at service time.
- Target change mid-slew: the new target is used at the next service. No restart.
- tick on consecutive cycles is legal: one service per clk.

Optional Feature:
CURRENTLIMIT_SYNC_EN
- Defined: each currentlimitk passes through a 2-flop synchronizer (reset to 0) before use as cl_k. This adds 2 clk of sampling latency.
- Undefined: cl_k = currentlimitk directly (inputs already synchronous).

Test Plan:
- Reset, motorena=1, STEP=1, target0=0x40, tick every clk -> duty0 reaches 0x40 after 64 services (192 ticks), settled[0]=1, duty1=duty2=0, slot cycles 0,1,2.
- duty1 settled at 0xC0, target1 set to 0x80, STEP=16 -> duty1 goes 0xB0,0xA0,0x90,0x80 on successive channel-1 services, then holds.
- duty0 settled at 0x80, pulse currentlimit0 for one service -> duty0=0x40, limiting[0]=1 for 16 channel-0 services with no increase, then slews back to 0x80.
- Mid-slew, motorena=0 for 1 clk -> next cycle duty0..2=0, slot=0. motorena=1 -> slewing restarts from 0.
- Assert reset asynchronously mid-slew (between clk edges) -> all outputs 0 immediately, without waiting for clk.
- target2=0xFF, STEP=200, duty2=0xF0 -> duty2=0xFF with no wrap. Then target2=0x00 -> duty2=0x37, then 0x00.
